serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtractor controller: computes diff = a − b − bin over WIDTH clock cycles using a single full-subtractor bit cell. The cell computes d = a^b^c and bout = (~a&b)|(b&c)|(c&~a). The controller latches the operands, shifts them LSB-first through the cell, and recirculates the borrow through a register. It sits between a requester with a start/done handshake and the shared one-bit subtractor datapath, trading latency for area in multi-bit subtract operations.

## Interface
- WIDTH, default 8: operand/result width in bits. Legal range is WIDTH ≥ 1.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request to begin an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accept edge.
- b  input  WIDTH  subtrahend; captured on the accept edge.
- bin  input  1  borrow-in; captured on the accept edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse while in DONE.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH; held until the next DONE or rst.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned); held like diff.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; all outputs are registered or decoded from state only.
- Internal registers:
  - sa, sb: WIDTH-bit operand shift registers.
  - br: 1-bit borrow register.
  - sr: WIDTH-bit result shift register.
  - cnt: counter of width max(1, clog2(WIDTH)).
- IDLE:
  - If start=1 at the edge: sa←a, sb←b, br←bin, cnt←0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - d = sa[0]^sb[0]^br; bo = (~sa[0]&sb[0])|(sb[0]&br)|(br&~sa[0]).
  - sr←{d, sr[WIDTH-1:1]}; sa, sb shift right by 1; br←bo; cnt←cnt+1.
  - When cnt==WIDTH-1: diff←{d, sr[WIDTH-1:1]}, bout←bo, go to DONE.
- DONE: done=1 for exactly one cycle; unconditionally go to IDLE at the next edge.
- start is ignored in RUN and DONE: no queuing and no restart. Operand inputs are don't-care outside the accept edge.
- Reset (any state, including mid-RUN):
  - State←IDLE; busy=0, done=0, diff=0, bout=0.
  - sa, sb, sr, br, cnt cleared.
  - An in-flight operation is discarded with no done pulse.
  - rst takes priority over a simultaneous start.
- WIDTH=1: RUN lasts exactly one cycle (cnt==0==WIDTH-1 on the first RUN edge).

## Timing
- Accept edge E0: start sampled high in IDLE.
- busy is high for the WIDTH cycles after E0 (edges E1..E_WIDTH process bits 0..WIDTH-1).
- done is high, and diff/bout take their new values, in the cycle after edge E_WIDTH.
  - Latency from accept to done = WIDTH cycles.
  - done is never high in the same cycle as busy.
- Earliest next accept is the edge after DONE.
  - With start held high continuously, throughput is one operation per WIDTH+2 cycles.
- diff/bout change only on the DONE-entry edge or on rst; they are stable at all other times.

## Test plan
- Basic subtract (WIDTH=8): a=0x5A, b=0x3C, bin=0 → done exactly 8 cycles after accept; diff=0x1E, bout=0; busy high for 8 cycles.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 → diff=0x00, bout=0.
- Start ignored while busy:
  - Accept a=0x10, b=0x01; pulse start with a=0xFF, b=0xFF during RUN and during DONE.
  - Expect a single done with diff=0x0F, bout=0.
  - No second operation starts without a fresh start in IDLE.
- Reset mid-operation:
  - Assert rst at the 4th RUN cycle → next cycle state IDLE, busy=0, diff=0, bout=0, no done.
  - A following op a=0x03, b=0x05 → diff=0xFE, bout=1.
- Back-to-back with start held high:
  - Two ops, 0xFF−0x00 then 0x00−0xFF with bin=1 → done pulses 10 cycles apart.
  - Results 0xFF/0 then 0x00/1.
- WIDTH=1 exhaustive: all 8 (a,b,bin) combinations → done 1 cycle after accept; diff/bout match the full-subtractor truth table (e.g. a=0, b=1, bin=1 → diff=0, bout=1).

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin using one full-subtractor cell over WIDTH cycles
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, sr, nsr;
    logic             br, d, bo;
    logic [CW-1:0]    cnt;

    assign d  = sa[0] ^ sb[0] ^ br;
    assign bo = (~sa[0] & sb[0]) | (sb[0] & br) | (br & ~sa[0]);

    generate
        if (WIDTH == 1) begin : g_one
            assign nsr = d;
        end else begin : g_many
            assign nsr = {d, sr[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and serial datapath; busy/done/diff/bout are registered with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sr  <= nsr;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= nsr;
                        bout  <= bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_sub_ctrl;
    typedef struct {
        logic [7:0] d;
        logic       bo;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1, rst1 = 1'b1;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, busy8, done8, bout8;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       bin1 = 1'b0, busy1, done1, bout1;

    int   tests = 0, fails = 0, cyc = 0, run8 = 0, run1 = 0;
    exp_t q8[$], q1[$];

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a done pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk("busy_with_done8", busy8, 0);
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done8: got done at cycle %0d expected none", cyc);
            end else begin
                e = q8.pop_front();
                chk("diff8", diff8, e.d);
                chk("bout8", bout8, e.bo);
                chk("done_cycle8", cyc, e.due);
                chk("busy_len8", run8, 8);
            end
        end
        run8 = busy8 ? run8 + 1 : 0;
        if (done1) begin
            chk("busy_with_done1", busy1, 0);
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done1: got done at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("diff1", diff1, e.d);
                chk("bout1", bout1, e.bo);
                chk("done_cycle1", cyc, e.due);
                chk("busy_len1", run1, 1);
            end
        end
        run1 = busy1 ? run1 + 1 : 0;
    end

    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int k);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = cyc;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] d, input logic bo);
        int k;
        accept8(a, b, bi, k);
        q8.push_back('{d, bo, k + 8});
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        chk("drain8", q8.size(), 0);
    endtask

    task automatic drain1();
        for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
        chk("drain1", q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst1 = 1'b0;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_diff1", diff1, 0);

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        drain8();
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        drain8();
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        drain8();

        // start pulses during RUN and DONE must be ignored
        op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        repeat (8) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_start_busy8", busy8, 0);
        chk("ignored_start_diff8", diff8, 8'h0F);
        drain8();

        // reset in the 4th RUN cycle discards the operation
        accept8(8'h5A, 8'h3C, 1'b0, k);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy8", busy8, 1);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrst_busy8", busy8, 0);
        chk("midrst_done8", done8, 0);
        chk("midrst_diff8", diff8, 0);
        chk("midrst_bout8", bout8, 0);
        repeat (12) @(negedge clk);
        chk("midrst_idle_diff8", diff8, 0);
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        drain8();

        // start held high: done pulses WIDTH+2 cycles apart
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        k = cyc;
        q8.push_back('{8'hFF, 1'b0, k + 8});
        q8.push_back('{8'h00, 1'b1, k + 18});
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
        repeat (10) @(negedge clk);
        start8 = 1'b0;
        drain8();
        repeat (4) @(negedge clk);
        chk("b2b_idle_busy8", busy8, 0);

        // WIDTH=1 exhaustive truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] t;
            int         ex;
            t = 3'(v);
            ex = int'(t[2]) - int'(t[1]) - int'(t[0]);
            @(negedge clk);
            a1 = t[2]; b1 = t[1]; bin1 = t[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            k = cyc;
            q1.push_back('{{7'b0, t[2] ^ t[1] ^ t[0]}, ex < 0, k + 1});
            drain1();
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
